// File: rtl/mem_wb_stage.sv
// Purpose: MIPS M stage (word-addressed data memory, lw/sw) plus the M/W pipeline register.
// Latency: 1 cycle M->W for every output; a store is visible to a load in M on the next cycle.
// Backpressure: none. One instruction per cycle is accepted unconditionally; bubbles are instr_M=0.
// Optional: define DM_TRACE_EN to print a trace line for every committed store (simulation only).
module mem_wb_stage #(
  parameter int          DM_AW   = 10,
  parameter logic [31:0] DM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_M,
  input  logic [31:0] pc4_M,
  input  logic [31:0] ao_M,
  input  logic [31:0] st_data_M,
  input  logic [4:0]  a3_M,
  input  logic        regwr_M,
  output logic [31:0] instr_W,
  output logic [5:0]  op_W,
  output logic [5:0]  func_W,
  output logic [31:0] pc4_W,
  output logic [31:0] ao_W,
  output logic [31:0] dr_W,
  output logic [4:0]  a3_W,
  output logic        regwr_W
);

  localparam int          DM_DEPTH = 1 << DM_AW;
  localparam logic [5:0]  OP_SW    = 6'b101011;

  // Opcode of the instruction currently in M
  logic [5:0] op_M;
  assign op_M = instr_M[31:26];

  // Only stores need a decode here: loads need no special handling because
  // dr_W always captures the addressed word, which keeps it deterministic
  // for non-load instructions too.
  logic is_sw;
  assign is_sw = (op_M == OP_SW);

  // Byte offset from the DM window base. Low two bits are dropped (no
  // misalignment trap) and bits above the word index are dropped, so
  // addresses alias modulo 2**(DM_AW+2) bytes.
  logic [31:0]      addr_off;
  logic [DM_AW-1:0] dm_idx;
  assign addr_off = ao_M - DM_BASE;
  assign dm_idx   = addr_off[DM_AW+1:2];

  // Deliberately discarded address bits
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr_off[31:DM_AW+2], addr_off[1:0]};

  // Data memory as flops: a synchronous reset must clear every word at once
  logic [31:0] dm [DM_DEPTH];

  // DM update: clear everything on reset (reset beats a store in flight), else commit sw
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DM_DEPTH; i++) begin
        dm[i] <= '0;
      end
    end else if (is_sw) begin
      dm[dm_idx] <= st_data_M;
    end
  end

  // M/W pipeline register; dr_W samples the word as it was before this edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_W <= '0;
      pc4_W   <= '0;
      ao_W    <= '0;
      dr_W    <= '0;
      a3_W    <= '0;
      regwr_W <= 1'b0;
    end else begin
      instr_W <= instr_M;
      pc4_W   <= pc4_M;
      ao_W    <= ao_M;
      dr_W    <= dm[dm_idx];
      a3_W    <= a3_M;
      regwr_W <= regwr_M;
    end
  end

  // Field views of the registered instruction, not separately stored
  assign op_W   = instr_W[31:26];
  assign func_W = instr_W[5:0];

`ifdef DM_TRACE_EN
  // Store trace: one line per committed sw, suppressed while in reset
  always_ff @(posedge clk) begin
    if (reset_n && is_sw) begin
      $display("%d@%h: *%h <= %h", $time, pc4_M - 32'd4, {ao_M[31:2], 2'b00}, st_data_M);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors, a behavioural reference model
// compared every cycle after the first reset, plus literal expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_M, pc4_M, ao_M, st_data_M;
  logic [4:0]  a3_M;
  logic        regwr_M;
  logic [31:0] instr_W, pc4_W, ao_W, dr_W;
  logic [5:0]  op_W, func_W;
  logic [4:0]  a3_W;
  logic        regwr_W;

  int n_vec  = 0;
  int n_fail = 0;

  mem_wb_stage #(.DM_AW(10), .DM_BASE(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_M(instr_M), .pc4_M(pc4_M), .ao_M(ao_M), .st_data_M(st_data_M),
    .a3_M(a3_M), .regwr_M(regwr_M),
    .instr_W(instr_W), .op_W(op_W), .func_W(func_W), .pc4_W(pc4_W),
    .ao_W(ao_W), .dr_W(dr_W), .a3_W(a3_W), .regwr_W(regwr_W)
  );

  always #5 clk = ~clk;

  // Reference model: a plain word array and the expected W values
  logic [31:0] m_mem [1024];
  logic [31:0] m_instr, m_pc4, m_ao, m_dr;
  logic [4:0]  m_a3;
  logic        m_regwr;
  bit          m_valid = 0;

  always @(posedge clk) begin
    int unsigned idx;
    idx = (ao_M >> 2) % 1024;
    if (!reset_n) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_instr = 0; m_pc4 = 0; m_ao = 0; m_dr = 0; m_a3 = 0; m_regwr = 0;
      m_valid = 1;
    end else begin
      m_dr    = m_mem[idx];
      if (instr_M[31:26] == 6'h2B) m_mem[idx] = st_data_M;
      m_instr = instr_M;
      m_pc4   = pc4_M;
      m_ao    = ao_M;
      m_a3    = a3_M;
      m_regwr = regwr_M;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model once the first reset has been seen
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_instr_W", instr_W, m_instr);
      check("cyc_op_W",    {26'h0, op_W}, {26'h0, m_instr[31:26]});
      check("cyc_func_W",  {26'h0, func_W}, {26'h0, m_instr[5:0]});
      check("cyc_pc4_W",   pc4_W, m_pc4);
      check("cyc_ao_W",    ao_W, m_ao);
      check("cyc_dr_W",    dr_W, m_dr);
      check("cyc_a3_W",    {27'h0, a3_W}, {27'h0, m_a3});
      check("cyc_regwr_W", {31'h0, regwr_W}, {31'h0, m_regwr});
    end
  end

  function automatic logic [31:0] sw_i(input logic [4:0] rt);
    return {6'h2B, 5'd0, rt, 16'h0};
  endfunction
  function automatic logic [31:0] lw_i(input logic [4:0] rt);
    return {6'h23, 5'd0, rt, 16'h0};
  endfunction

  // Apply one M-stage instruction; returns at the negedge after it was clocked
  task automatic drive(input logic rst_n, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] ao, input logic [31:0] st,
                       input logic [4:0] a3, input logic rw);
    reset_n = rst_n; instr_M = ins; pc4_M = pc4; ao_M = ao;
    st_data_M = st; a3_M = a3; regwr_M = rw;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; instr_M = 0; pc4_M = 0; ao_M = 0; st_data_M = 0; a3_M = 0; regwr_M = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Fill DM[0..3] so the next reset has something to clear
    for (int i = 0; i < 4; i++)
      drive(1, sw_i(5'd2), 32'h3004 + 4*i, 4*i, 32'h1111_1111 * (i + 1), 0, 0);

    // Test 1: two reset cycles with a store pending
    drive(0, sw_i(5'd3), 32'h3100, 32'h0, 32'hFFFF_FFFF, 5'd7, 1);
    drive(0, sw_i(5'd3), 32'h3104, 32'h4, 32'hFFFF_FFFF, 5'd7, 1);
    check("rst_instr_W", instr_W, 0);
    check("rst_pc4_W",   pc4_W, 0);
    check("rst_ao_W",    ao_W, 0);
    check("rst_dr_W",    dr_W, 0);
    check("rst_a3_W",    {27'h0, a3_W}, 0);
    check("rst_regwr_W", {31'h0, regwr_W}, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, lw_i(5'd4), 32'h3200 + 4*i, 4*i, 0, 5'd4, 1);
      check("rst_dm_clear", dr_W, 0);
    end

    // Test 2: sw then lw same address
    drive(1, sw_i(5'd5), 32'h3300, 32'h4, 32'hDEAD_BEEF, 0, 0);
    drive(1, lw_i(5'd6), 32'h3304, 32'h4, 0, 5'd6, 1);
    check("sw_lw_fwd", dr_W, 32'hDEAD_BEEF);

    // Test 3: misaligned load ignores low address bits
    drive(1, sw_i(5'd5), 32'h3308, 32'h8, 32'hCAFE_F00D, 0, 0);
    drive(1, lw_i(5'd6), 32'h330C, 32'h9, 0, 5'd6, 1);
    check("misalign_lw", dr_W, 32'hCAFE_F00D);

    // Test 4: aliasing above the DM window
    drive(1, sw_i(5'd5), 32'h3310, 32'h1000, 32'h1234_5678, 0, 0);
    drive(1, lw_i(5'd6), 32'h3314, 32'h0, 0, 5'd6, 1);
    check("alias_lw", dr_W, 32'h1234_5678);

    // Test 5: lui pass-through, DM untouched
    drive(1, 32'h3C01_1234, 32'h3004, 32'h1234_0000, 32'h5555_5555, 5'd1, 1);
    check("lui_op_W",    {26'h0, op_W}, 32'h0F);
    check("lui_func_W",  {26'h0, func_W}, 32'h34);
    check("lui_pc4_W",   pc4_W, 32'h3004);
    check("lui_a3_W",    {27'h0, a3_W}, 1);
    check("lui_regwr_W", {31'h0, regwr_W}, 1);
    drive(1, lw_i(5'd6), 32'h3318, 32'h0, 0, 5'd6, 1);
    check("lui_no_dm", dr_W, 32'h1234_5678);

    // Store with regwr asserted: regwr_W mirrors it unmodified
    drive(1, sw_i(5'd5), 32'h331C, 32'hFFC, 32'hA5A5_0001, 5'd9, 1);
    check("sw_regwr_W", {31'h0, regwr_W}, 1);
    drive(1, lw_i(5'd6), 32'h3320, 32'hFFC, 0, 5'd6, 1);
    check("top_word_lw", dr_W, 32'hA5A5_0001);

    // Back-to-back stores then loads
    drive(1, sw_i(5'd5), 32'h3324, 32'h20, 32'h0000_00AA, 0, 0);
    drive(1, sw_i(5'd5), 32'h3328, 32'h20, 32'h0000_00BB, 0, 0);
    drive(1, lw_i(5'd6), 32'h332C, 32'h23, 0, 5'd6, 1);
    check("last_store_wins", dr_W, 32'h0000_00BB);

    // Test 6: reset coincides with sw 0x10
    drive(0, sw_i(5'd5), 32'h3330, 32'h10, 32'h0000_00AA, 0, 0);
    drive(1, lw_i(5'd6), 32'h3334, 32'h10, 0, 5'd6, 1);
    check("rst_blocks_sw", dr_W, 0);
    drive(1, lw_i(5'd6), 32'h3338, 32'h4, 0, 5'd6, 1);
    check("rst_clears_beef", dr_W, 0);

    drive(1, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
